// File: rtl/vertex_transform_stage.sv
// vertex_transform_stage: multiplies an object-space vertex (x, y, z, 1) by a
// double-buffered 4x4 QM.N matrix and emits integer screen coordinates.
// One vertex is processed at a time: 4 MAC cycles, then the result is held
// until the downstream consumer takes it.
// Optional feature macro: VERTEX_SAT_EN. When it is defined, results that do
// not fit in M bits clamp and raise out_sat. When it is undefined, results
// wrap and out_sat is tied to 0.
module vertex_transform_stage #(
  parameter int M = 11,
  parameter int N = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mat_we,
  input  logic [3:0]            mat_addr,
  input  logic signed [M+N-1:0] mat_wdata,
  input  logic                  mat_swap,
  output logic                  swap_pending,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [M+N-1:0] in_x,
  input  logic signed [M+N-1:0] in_y,
  input  logic signed [M+N-1:0] in_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [M-1:0]   out_x,
  output logic signed [M-1:0]   out_y,
  output logic signed [M-1:0]   out_z,
  output logic                  out_sat
);

  localparam int W  = M + N;
  localparam int PW = 2 * W;
  localparam int AW = PW + 2;
  localparam logic signed [W-1:0] ONE = W'(1 << N);

`ifdef VERTEX_SAT_EN
  localparam logic signed [AW-1:0] OUT_MAX = AW'((1 << (M - 1)) - 1);
  localparam logic signed [AW-1:0] OUT_MIN = AW'(-(1 << (M - 1)));
`endif

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t state_q, state_d;
  logic [1:0] col_q, col_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic pending_q, pending_d;
  logic accept, copy, load;

  logic signed [W-1:0]  shadow_q [16];
  logic signed [W-1:0]  active_q [16];
  logic signed [W-1:0]  vx_q, vy_q, vz_q;
  logic signed [W-1:0]  vsel;
  logic signed [PW-1:0] prod [3];
  logic signed [AW-1:0] acc_q [3];
  logic signed [M-1:0]  ox_q, oy_q, oz_q;

  // Drop the 2N fractional bits (floor) and fit the result into M bits.
  function automatic logic signed [M-1:0] reduce(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] s;
    s = acc >>> (2 * N);
`ifdef VERTEX_SAT_EN
    if (s > OUT_MAX)      reduce = M'(OUT_MAX);
    else if (s < OUT_MIN) reduce = M'(OUT_MIN);
    else                  reduce = M'(s);
`else
    reduce = M'(s);
`endif
  endfunction

`ifdef VERTEX_SAT_EN
  // True when the floored result does not fit in M signed bits.
  function automatic logic overflow(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] s;
    s = acc >>> (2 * N);
    overflow = (s > OUT_MAX) || (s < OUT_MIN);
  endfunction
`endif

  // Next-state logic: sequencing, deferred swap and registered handshakes.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    accept      = (state_q == IDLE) && in_valid && in_ready_q;
    copy        = (state_q == IDLE) && pending_q && !accept;
    load        = (state_q == HOLD) && !out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          col_d   = 2'd0;
        end
      end
      MAC: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = HOLD;
      end
      HOLD: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d  = mat_swap || (pending_q && !copy);
    in_ready_d = (state_d == IDLE) && !pending_d;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
    end
  end

  // Matrix banks: shadow takes writes, active takes the shadow's pre-write contents on a swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= (i % 5 == 0) ? ONE : '0;
        active_q[i] <= (i % 5 == 0) ? ONE : '0;
      end
    end else begin
      if (mat_we) shadow_q[mat_addr] <= mat_wdata;
      if (copy)   active_q <= shadow_q;
    end
  end

  // Column operand and three parallel row multipliers; the w column is an implicit 1.0.
  always_comb begin
    case (col_q)
      2'd0:    vsel = vx_q;
      2'd1:    vsel = vy_q;
      2'd2:    vsel = vz_q;
      default: vsel = ONE;
    endcase
    for (int r = 0; r < 3; r++) begin
      prod[r] = active_q[{2'(r), col_q}] * vsel;
    end
  end

  // Vertex latch and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) acc_q[r] <= '0;
    end else if (accept) begin
      vx_q <= in_x;
      vy_q <= in_y;
      vz_q <= in_z;
      for (int r = 0; r < 3; r++) acc_q[r] <= '0;
    end else if (state_q == MAC) begin
      for (int r = 0; r < 3; r++) acc_q[r] <= acc_q[r] + AW'(prod[r]);
    end
  end

  // Result registers: loaded once per vertex, frozen while the output waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ox_q <= '0;
      oy_q <= '0;
      oz_q <= '0;
    end else if (load) begin
      ox_q <= reduce(acc_q[0]);
      oy_q <= reduce(acc_q[1]);
      oz_q <= reduce(acc_q[2]);
    end
  end

`ifdef VERTEX_SAT_EN
  logic out_sat_q;

  // Saturation flag for the vertex being held.
  always_ff @(posedge clk) begin
    if (rst)       out_sat_q <= 1'b0;
    else if (load) out_sat_q <= overflow(acc_q[0]) | overflow(acc_q[1]) | overflow(acc_q[2]);
  end

  assign out_sat = out_sat_q;
`else
  assign out_sat = 1'b0;
`endif

  assign swap_pending = pending_q;
  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_x        = ox_q;
  assign out_y        = oy_q;
  assign out_z        = oz_q;

endmodule
